input_unit: RTL

Operator-entry block feeding the processor's IN instruction; it is the input-side counterpart of the output/display unit. On a processor read request it waits for the operator to set two BCD digit switch banks and a sign switch, then press and release a push button. It debounces the button, validates the digits, converts sign plus two decimal digits into a 16-bit two's-complement word, and returns that word with a one-cycle completion pulse.

---
 rtl/input_unit.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/input_unit.sv
// ============================================================================
// Module   : input_unit
// Brief    : Operator entry for the IN instruction: debounced key, BCD digits
//            plus sign converted to a 16-bit two's-complement word.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module input_unit #(
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic        c,
   input  logic        reset,
   input  logic        in,
   input  logic [3:0]  sw_tens,
   input  logic [3:0]  sw_ones,
   input  logic        sw_neg,
   input  logic        key_n,
   output logic [15:0] in_data,
   output logic        in_done,
   output logic        waiting,
   output logic        in_err
);

   localparam int                 c_CNT_W   = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DEBOUNCE_CYCLES - 1);

   localparam logic [2:0] c_IDLE         = 3'd0;
   localparam logic [2:0] c_WAIT_PRESS   = 3'd1;
   localparam logic [2:0] c_WAIT_RELEASE = 3'd2;
   localparam logic [2:0] c_CONVERT      = 3'd3;
   localparam logic [2:0] c_DONE         = 3'd4;

   logic [2:0]         r_state;
   logic [2:0]         w_state_nxt;
   logic               r_sync1;
   logic               r_sync2;
   logic               r_key_clean;
   logic               r_key_prev;
   logic [c_CNT_W-1:0] r_cnt;
   logic               r_in_q;
   logic [3:0]         r_tens;
   logic [3:0]         r_ones;
   logic               r_neg;
   logic [15:0]        r_data;
   logic               r_err;
   logic               w_req;
   logic               w_press;
   logic               w_release;
   logic               w_bad;
   logic               w_latch;
   logic [6:0]         w_mag;
   logic [15:0]        w_mag16;
   logic [15:0]        w_conv;

   // Synchronizer, debouncer and edge history; idle level of the key is high.
   always_ff @(posedge c) begin
      if (reset) begin
         r_sync1     <= 1'b1;
         r_sync2     <= 1'b1;
         r_key_clean <= 1'b1;
         r_key_prev  <= 1'b1;
         r_cnt       <= '0;
         r_in_q      <= 1'b0;
      end else begin
         r_sync1    <= key_n;
         r_sync2    <= r_sync1;
         r_key_prev <= r_key_clean;
         r_in_q     <= in;
         if (r_sync2 == r_key_clean) begin
            r_cnt <= '0;
         end else if (r_cnt == c_CNT_MAX) begin
            r_key_clean <= r_sync2;
            r_cnt       <= '0;
         end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
         end
      end
   end

   // Edge-based press means a key already held at read start is ignored.
   assign w_press   = r_key_prev & ~r_key_clean;
   assign w_release = ~r_key_prev & r_key_clean;
   assign w_req     = in & ~r_in_q;
   assign w_bad     = (sw_tens > 4'd9) | (sw_ones > 4'd9);
   assign w_latch   = (r_state == c_WAIT_PRESS) & in & w_press;

   assign w_mag   = {r_tens, 3'b000} + {2'b00, r_tens, 1'b0} + {3'b000, r_ones};
   assign w_mag16 = {9'd0, w_mag};
   assign w_conv  = r_neg ? (~w_mag16 + 16'd1) : w_mag16;

   always_ff @(posedge c) begin
      if (reset) begin
         r_state <= c_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_IDLE: begin
            if (w_req) w_state_nxt = c_WAIT_PRESS;
         end
         c_WAIT_PRESS: begin
            if (!in)          w_state_nxt = c_IDLE;
            else if (w_press) w_state_nxt = c_WAIT_RELEASE;
         end
         c_WAIT_RELEASE: begin
            if (!in)            w_state_nxt = c_IDLE;
            else if (w_release) w_state_nxt = r_err ? c_WAIT_PRESS : c_CONVERT;
         end
         c_CONVERT: w_state_nxt = c_DONE;
         c_DONE:    w_state_nxt = c_IDLE;
         default:   w_state_nxt = c_IDLE;
      endcase
   end

   always_comb begin
      waiting = (r_state == c_WAIT_PRESS) | (r_state == c_WAIT_RELEASE);
      in_done = (r_state == c_DONE);
   end

   // Capture registers and result; in_data only changes on a conversion.
   always_ff @(posedge c) begin
      if (reset) begin
         r_tens <= 4'd0;
         r_ones <= 4'd0;
         r_neg  <= 1'b0;
         r_data <= 16'd0;
         r_err  <= 1'b0;
      end else begin
         if ((r_state == c_IDLE) && w_req) begin
            r_err <= 1'b0;
         end
         if (w_latch) begin
            r_tens <= sw_tens;
            r_ones <= sw_ones;
            r_neg  <= sw_neg;
            r_err  <= w_bad;
         end
         if (r_state == c_CONVERT) begin
            r_data <= w_conv;
         end
      end
   end

   assign in_data = r_data;
   assign in_err  = r_err;

endmodule

`default_nettype wire
